ipml_reg_fifo_v2_0_wr_fifo: RTL and testbench

Parametrised register-based FIFO with valid/ready handshaking on both sides. It generalises the fixed two-entry register FIFO to any power-of-two depth and adds an occupancy count, an almost-full flag and a synchronous flush. It sits between a streaming producer and a consumer inside IP wrappers, where short elastic buffering is needed without block RAM.

---
 rtl/ipml_reg_fifo_v2_0_wr_fifo.sv | 156 +++++++++++++++
 tb/tb_ipml_reg_fifo_v2_0_wr_fifo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ipml_reg_fifo_v2_0_wr_fifo.sv
// ipml_reg_fifo_v2_0_wr_fifo
// Register-based FIFO with valid/ready handshakes on both sides. DEPTH must be
// a power of two (>= 2). The block reports occupancy (level) and an almost_full
// flag, and a synchronous flush clears it.
//
// Optional build macro: IPML_REG_FIFO_OUT_REG_EN
//   undefined : data_out is a combinational mux of the array at the read pointer
//   defined   : data_out comes from a dedicated register that is preloaded with
//               the next head word
// Handshakes, level and flags are cycle-identical in both builds. In both builds
// data_out reads as zero whenever the FIFO is empty, which also makes it zero
// after reset.
module ipml_reg_fifo_v2_0_wr_fifo #(
  parameter int W        = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          data_in_valid,
  input  logic [W-1:0]  data_in,
  output logic          data_in_ready,
  input  logic          data_out_ready,
  output logic [W-1:0]  data_out,
  output logic          data_out_valid,
  output logic [AW:0]   level,
  output logic          almost_full
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_AF   = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem_r [DEPTH];
  logic [AW:0]  wptr_r;
  logic [AW:0]  rptr_r;
  logic [AW:0]  level_r;
  logic         almost_full_r;

  logic [AW:0]  wptr_nxt_s;
  logic [AW:0]  rptr_nxt_s;
  logic [AW:0]  level_nxt_s;
  logic         fifo_write_s;
  logic         fifo_read_s;
  logic         in_ready_s;
  logic         out_valid_s;

  // Handshake qualifiers: flush masks both sides, ready never looks at the read side.
  always_comb begin
    in_ready_s   = ~flush & (level_r != LVL_FULL);
    out_valid_s  = ~flush & (level_r != PTR_ZERO);
    fifo_write_s = data_in_valid & in_ready_s;
    fifo_read_s  = out_valid_s & data_out_ready;
  end

  assign data_in_ready  = in_ready_s;
  assign data_out_valid = out_valid_s;
  assign level          = level_r;
  assign almost_full    = almost_full_r;

  // Next pointer and occupancy values; flush takes priority over all traffic.
  always_comb begin
    wptr_nxt_s  = wptr_r;
    rptr_nxt_s  = rptr_r;
    level_nxt_s = level_r;
    if (flush) begin
      wptr_nxt_s  = PTR_ZERO;
      rptr_nxt_s  = PTR_ZERO;
      level_nxt_s = PTR_ZERO;
    end else begin
      if (fifo_write_s) begin
        wptr_nxt_s = wptr_r + PTR_ONE;
      end else begin
        wptr_nxt_s = wptr_r;
      end
      if (fifo_read_s) begin
        rptr_nxt_s = rptr_r + PTR_ONE;
      end else begin
        rptr_nxt_s = rptr_r;
      end
      case ({fifo_write_s, fifo_read_s})
        2'b10:   level_nxt_s = level_r + PTR_ONE;
        2'b01:   level_nxt_s = level_r - PTR_ONE;
        default: level_nxt_s = level_r;
      endcase
    end
  end

  // Pointer, level and almost_full state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r        <= PTR_ZERO;
      rptr_r        <= PTR_ZERO;
      level_r       <= PTR_ZERO;
      almost_full_r <= 1'b0;
    end else begin
      wptr_r        <= wptr_nxt_s;
      rptr_r        <= rptr_nxt_s;
      level_r       <= level_nxt_s;
      almost_full_r <= (level_nxt_s >= LVL_AF);
    end
  end

  // Storage array; contents are never reset and survive flush.
  always_ff @(posedge clk) begin
    if (fifo_write_s) begin
      mem_r[wptr_r[AW-1:0]] <= data_in;
    end
  end

`ifdef IPML_REG_FIFO_OUT_REG_EN
  logic [W-1:0] dout_r;
  logic [W-1:0] dout_nxt_s;

  // Next head word: a same-cycle write into the next head slot bypasses the array.
  always_comb begin
    dout_nxt_s = {W{1'b0}};
    if (level_nxt_s == PTR_ZERO) begin
      dout_nxt_s = {W{1'b0}};
    end else if (fifo_write_s && (wptr_r[AW-1:0] == rptr_nxt_s[AW-1:0])) begin
      dout_nxt_s = data_in;
    end else begin
      dout_nxt_s = mem_r[rptr_nxt_s[AW-1:0]];
    end
  end

  // Output data register, reloaded every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r <= {W{1'b0}};
    end else begin
      dout_r <= dout_nxt_s;
    end
  end

  assign data_out = dout_r;
`else
  logic [W-1:0] dout_s;

  // Head word straight from the array; forced to zero while empty.
  always_comb begin
    dout_s = {W{1'b0}};
    if (level_r != PTR_ZERO) begin
      dout_s = mem_r[rptr_r[AW-1:0]];
    end else begin
      dout_s = {W{1'b0}};
    end
  end

  assign data_out = dout_s;
`endif

endmodule

// File: tb/tb_ipml_reg_fifo_v2_0_wr_fifo.sv
// Self-checking bench for ipml_reg_fifo_v2_0_wr_fifo (W=8, DEPTH=4, AF_LEVEL=3).
// The reference model is a plain queue of accepted words.
module tb_ipml_reg_fifo_v2_0_wr_fifo;

  localparam int DEPTH = 4;
  localparam int AFL   = 3;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       vin;
  logic [7:0] din;
  logic       in_ready;
  logic       oready;
  logic [7:0] dout;
  logic       ovalid;
  logic [2:0] lvl;
  logic       af;

  int tests;
  int fails;
  logic [7:0] q[$];

  ipml_reg_fifo_v2_0_wr_fifo #(.W(8), .DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .data_in_valid(vin), .data_in(din), .data_in_ready(in_ready),
    .data_out_ready(oready), .data_out(dout), .data_out_valid(ovalid),
    .level(lvl), .almost_full(af)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge: update the reference queue from the inputs, return at negedge.
  task automatic cyc();
    bit wr;
    bit rd;
    @(posedge clk);
    wr = rst_n && vin && !flush && (q.size() < DEPTH);
    rd = rst_n && oready && !flush && (q.size() > 0);
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      if (rd) void'(q.pop_front());
      if (wr) q.push_back(din);
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; flush = 1'b0; vin = 1'b0; din = 8'h00; oready = 1'b0;
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; vin = 1'b0; din = 8'h00; oready = 1'b0;
    q.delete();
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    tests++; if (ovalid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", ovalid); end
    tests++; if (lvl !== 3'd0) begin fails++; $display("FAIL reset_level got=%0d exp=0", lvl); end
    tests++; if (af !== 1'b0) begin fails++; $display("FAIL reset_af got=%b exp=0", af); end
    tests++; if (dout !== 8'h00) begin fails++; $display("FAIL reset_dout got=%h exp=00", dout); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++; if (dout !== 8'h00 || ovalid !== 1'b0) begin fails++; $display("FAIL reset_release got=%h/%b exp=00/0", dout, ovalid); end
    @(negedge clk);
  endtask

  task automatic test_fill_full();
    logic [7:0] words [4];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    apply_reset();
    oready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vin = 1'b1; din = words[i];
      cyc();
      #1;
      tests++; if (lvl !== 3'(i + 1)) begin fails++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, lvl, i + 1); end
      tests++; if (af !== (i >= 2)) begin fails++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, af, (i >= 2)); end
    end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_ready got=%b exp=0", in_ready); end
    din = 8'h99;
    cyc();
    #1;
    tests++; if (lvl !== 3'd4) begin fails++; $display("FAIL fifth_word_level got=%0d exp=4", lvl); end
    tests++; if (dout !== 8'h11) begin fails++; $display("FAIL full_head got=%h exp=11", dout); end
  endtask

  // Continues from a full FIFO holding 11,22,33,44.
  task automatic test_full_read_write();
    vin = 1'b1; din = 8'h55; oready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fullrw_ready got=%b exp=0", in_ready); end
    cyc();
    oready = 1'b0;
    #1;
    tests++; if (lvl !== 3'd3) begin fails++; $display("FAIL fullrw_level got=%0d exp=3", lvl); end
    tests++; if (dout !== 8'h22) begin fails++; $display("FAIL fullrw_head got=%h exp=22", dout); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL fullrw_ready_back got=%b exp=1", in_ready); end
    cyc();
    vin = 1'b0;
    #1;
    tests++; if (lvl !== 3'd4 || q.size() != 4 || q[3] != 8'h55) begin fails++; $display("FAIL fullrw_late_write got=%0d exp=4", lvl); end
  endtask

  task automatic test_streaming();
    apply_reset();
    oready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      vin = 1'b1; din = 8'(i);
      #1;
      if (i > 0) begin
        tests++; if (ovalid !== 1'b1 || dout !== 8'(i - 1)) begin fails++; $display("FAIL stream_out[%0d] got=%h/%b exp=%h/1", i, dout, ovalid, 8'(i - 1)); end
        tests++; if (lvl !== 3'd1 || in_ready !== 1'b1) begin fails++; $display("FAIL stream_level[%0d] got=%0d exp=1", i, lvl); end
      end
      cyc();
    end
    vin = 1'b0;
    #1;
    tests++; if (dout !== 8'h13 || ovalid !== 1'b1) begin fails++; $display("FAIL stream_last got=%h exp=13", dout); end
    cyc();
    #1;
    tests++; if (ovalid !== 1'b0 || lvl !== 3'd0) begin fails++; $display("FAIL stream_drain got=%b/%0d exp=0/0", ovalid, lvl); end
  endtask

  task automatic test_flush();
    apply_reset();
    oready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      vin = 1'b1; din = 8'(i);
      cyc();
    end
    flush = 1'b1; din = 8'hEE;
    #1;
    tests++; if (in_ready !== 1'b0 || ovalid !== 1'b0) begin fails++; $display("FAIL flush_mask got=%b/%b exp=0/0", in_ready, ovalid); end
    cyc();
    flush = 1'b0; vin = 1'b0;
    #1;
    tests++; if (lvl !== 3'd0 || ovalid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL flush_empty got=%0d/%b/%b exp=0/0/1", lvl, ovalid, in_ready); end
    vin = 1'b1; din = 8'hA5;
    cyc();
    vin = 1'b0; oready = 1'b1;
    #1;
    tests++; if (ovalid !== 1'b1 || dout !== 8'hA5 || lvl !== 3'd1) begin fails++; $display("FAIL flush_next got=%h/%0d exp=a5/1", dout, lvl); end
    cyc();
    oready = 1'b0;
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    oready = 1'b0;
    vin = 1'b1; din = 8'h61; cyc();
    din = 8'h62; cyc();
    rst_n = 1'b0; q.delete();
    #1;
    tests++; if (ovalid !== 1'b0 || in_ready !== 1'b1 || lvl !== 3'd0 || dout !== 8'h00) begin
      fails++; $display("FAIL midreset got=%b/%b/%0d/%h exp=0/1/0/00", ovalid, in_ready, lvl, dout);
    end
    @(negedge clk);
    rst_n = 1'b1; din = 8'h5C;
    cyc();
    din = 8'h5D;
    cyc();
    vin = 1'b0;
    #1;
    tests++; if (dout !== 8'h5C || lvl !== 3'd2) begin fails++; $display("FAIL midreset_first got=%h/%0d exp=5c/2", dout, lvl); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      vin    = ($urandom_range(0, 3) != 0);
      din    = 8'($urandom);
      oready = ($urandom_range(0, 2) != 0);
      flush  = ($urandom_range(0, 29) == 0);
      #1;
      tests++;
      if (in_ready !== (!flush && q.size() != DEPTH) ||
          ovalid   !== (!flush && q.size() != 0) ||
          lvl      !== 3'(q.size()) ||
          af       !== (q.size() >= AFL) ||
          (q.size() != 0 && dout !== q[0])) begin
        fails++;
        $display("FAIL random[%0d] got rdy=%b vld=%b lvl=%0d af=%b dout=%h exp size=%0d head=%h",
                 n, in_ready, ovalid, lvl, af, dout, q.size(), (q.size() != 0) ? q[0] : 8'h00);
      end
      cyc();
    end
    flush = 1'b0; vin = 1'b0; oready = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_fill_full();
    test_full_read_write();
    test_streaming();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
